// File: rtl/rv32_arith_core.sv
// rtl/rv32_arith_core.sv - single-cycle RV32I arithmetic/logic subset with program and data memories

// Program memory: combinational word read, contents loaded through the backdoor task.
module rv32_prog_mem #(
    parameter int WORDS = 256
) (
    input  logic [$clog2(WORDS)-1:0] addr_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] progArray [WORDS];

    // Asynchronous instruction fetch.
    assign rdata_o = progArray[addr_i];

    task initializeProgMem(input logic [31:0] fill);
        for (int i = 0; i < WORDS; i++) begin
            progArray[i] = fill;
        end
    endtask
endmodule

// Data memory: combinational read, write on the rising edge; never cleared by reset.
module rv32_data_mem #(
    parameter int WORDS = 256
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(WORDS)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] dataArray [WORDS];

    // Asynchronous load data.
    assign rdata_o = dataArray[addr_i];

    // Store commit.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            dataArray[addr_i] <= wdata_i;
        end
    end
endmodule

module rv32_arith_core #(
    parameter int PROG_WORDS = 256,
    parameter int DATA_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  dbg_reg_sel,
    output logic [31:0] dbg_reg_data,
    output logic [31:0] pc
);
    localparam int PAW = $clog2(PROG_WORDS);
    localparam int DAW = $clog2(DATA_WORDS);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [2:0] F3_WORD    = 3'b010;

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_u;
    logic [31:0] rs1_val, rs2_val;

    logic        rd_we_d;
    logic [31:0] rd_val_d;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_rdata;

    logic        unused_addr_bits;

    rv32_prog_mem #(.WORDS(PROG_WORDS)) mem_prog_inst (
        .addr_i  (pc_q[PAW+1:2]),
        .rdata_o (instr)
    );

    rv32_data_mem #(.WORDS(DATA_WORDS)) mem_data_inst (
        .clk_i   (clk),
        .we_i    (dmem_we),
        .addr_i  (dmem_addr[DAW+1:2]),
        .wdata_i (rs2_val),
        .rdata_o (dmem_rdata)
    );

    // Byte-offset and above-depth address bits are intentionally dropped.
    assign unused_addr_bits = ^{pc_q[31:PAW+2], pc_q[1:0], dmem_addr[31:DAW+2], dmem_addr[1:0]};

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};

    assign rs1_val      = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_val      = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
    assign dbg_reg_data = (dbg_reg_sel == 5'd0) ? 32'd0 : regs_q[dbg_reg_sel];
    assign pc           = pc_q;
    assign pc_d         = pc_q + 32'd4;

    // Shared ALU for register and immediate forms; sub only applies to R-type ADD.
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, input logic sub,
                                        input logic arith);
        logic [31:0] r;
        case (f3)
            3'b000:  r = sub ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = arith ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Decode and execute: choose the writeback value and the store strobe.
    always_comb begin
        rd_we_d   = 1'b0;
        rd_val_d  = 32'd0;
        dmem_we   = 1'b0;
        dmem_addr = rs1_val + imm_i;
        case (opcode)
            OPC_OP: begin
                rd_we_d  = 1'b1;
                rd_val_d = alu(funct3, rs1_val, rs2_val, instr[30], instr[30]);
            end
            OPC_OP_IMM: begin
                rd_we_d  = 1'b1;
                rd_val_d = alu(funct3, rs1_val, imm_i, 1'b0, instr[30]);
            end
            OPC_LUI: begin
                rd_we_d  = 1'b1;
                rd_val_d = imm_u;
            end
            OPC_LOAD: begin
                if (funct3 == F3_WORD) begin
                    rd_we_d  = 1'b1;
                    rd_val_d = dmem_rdata;
                end
            end
            OPC_STORE: begin
                dmem_addr = rs1_val + imm_s;
                // Reset at the edge suppresses the store along with everything else.
                dmem_we   = (funct3 == F3_WORD) && rst_n;
            end
            default: begin
                rd_we_d = 1'b0;
            end
        endcase
    end

    // PC and register file: cleared asynchronously, advanced/committed every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            pc_q <= pc_d;
            if (rd_we_d && (rd != 5'd0)) begin
                regs_q[rd] <= rd_val_d;
            end
        end
    end
endmodule

// File: tb/tb_rv32_arith_core.sv
// tb/tb_rv32_arith_core.sv - scoreboard bench for rv32_arith_core
module tb_rv32_arith_core;
    logic        clk;
    logic        rst_n;
    logic [4:0]  dbg_reg_sel;
    logic [31:0] dbg_reg_data;
    logic [31:0] pc;

    int n_checks;
    int n_fails;

    typedef struct {
        int          kind;   // 0 register, 1 pc, 2 data word
        int          idx;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] prog_q[$];

    rv32_arith_core #(.PROG_WORDS(256), .DATA_WORDS(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dbg_reg_sel  (dbg_reg_sel),
        .dbg_reg_data (dbg_reg_data),
        .pc           (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    function automatic logic [31:0] opi(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
        return enc_i(imm, rs1, f3, rd, 7'b0010011);
    endfunction

    task automatic expect_item(input int kind, input int idx, input logic [31:0] val, input string tag);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    // Hold reset, backdoor-load the queued program, release, run one cycle per instruction.
    task automatic run_prog();
        rst_n = 1'b0;
        @(negedge clk);
        dut.mem_prog_inst.initializeProgMem(32'h0000_0000);
        for (int i = 0; i < prog_q.size(); i++) begin
            dut.mem_prog_inst.progArray[i] = prog_q[i];
        end
        rst_n = 1'b1;
        repeat (prog_q.size()) @(posedge clk);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            case (e.kind)
                1: check_eq(e.tag, pc, e.val);
                2: check_eq(e.tag, dut.mem_data_inst.dataArray[e.idx], e.val);
                default: begin
                    dbg_reg_sel = 5'(e.idx);
                    #1;
                    check_eq(e.tag, dbg_reg_data, e.val);
                end
            endcase
        end
        prog_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        rst_n       = 1'b0;
        dbg_reg_sel = 5'd0;

        // Reset state.
        #3;
        check_eq("reset_pc", pc, 32'd0);
        dbg_reg_sel = 5'd7;
        #1;
        check_eq("reset_x7", dbg_reg_data, 32'd0);

        // ADD through loads and a store.
        rst_n = 1'b0;
        #1;
        dut.mem_data_inst.dataArray[0] = 32'd5;
        dut.mem_data_inst.dataArray[1] = 32'd7;
        dut.mem_data_inst.dataArray[2] = 32'd0;
        prog_q = '{enc_i(12'd0, 5'd0, 3'b010, 5'd1, 7'b0000011),
                   enc_i(12'd4, 5'd0, 3'b010, 5'd2, 7'b0000011),
                   enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3),
                   enc_s(12'd8, 5'd3, 5'd0)};
        expect_item(1, 0, 32'd16, "add_pc");
        expect_item(0, 1, 32'd5, "add_x1");
        expect_item(0, 2, 32'd7, "add_x2");
        expect_item(0, 3, 32'd12, "add_x3");
        expect_item(2, 2, 32'd12, "add_mem2");
        run_prog();

        // AND, then an asynchronous mid-run reset.
        prog_q = '{enc_lui(5'd1, 20'hF0F00), addi(5'd1, 5'd1, 12'h0FF),
                   enc_lui(5'd2, 20'h0FF01), addi(5'd2, 5'd2, 12'hF0F),
                   enc_r(7'd0, 5'd2, 5'd1, 3'b111, 5'd3)};
        expect_item(1, 0, 32'd20, "and_pc");
        expect_item(0, 1, 32'hF0F0_00FF, "and_x1");
        expect_item(0, 2, 32'h0FF0_0F0F, "and_x2");
        expect_item(0, 3, 32'h00F0_000F, "and_x3");
        run_prog();
        dbg_reg_sel = 5'd3;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midreset_pc", pc, 32'd0);
        check_eq("midreset_x3", dbg_reg_data, 32'd0);

        // ANDI.
        prog_q = '{enc_lui(5'd1, 20'h12345), addi(5'd1, 5'd1, 12'h678),
                   opi(3'b111, 5'd2, 5'd1, 12'h0FF), opi(3'b111, 5'd3, 5'd1, 12'hFFF)};
        expect_item(0, 1, 32'h1234_5678, "andi_x1");
        expect_item(0, 2, 32'h0000_0078, "andi_ff");
        expect_item(0, 3, 32'h1234_5678, "andi_m1");
        run_prog();

        // SLLI.
        prog_q = '{addi(5'd1, 5'd0, 12'd1),
                   opi(3'b001, 5'd2, 5'd1, 12'd31), opi(3'b001, 5'd3, 5'd1, 12'd0)};
        expect_item(0, 2, 32'h8000_0000, "slli_31");
        expect_item(0, 3, 32'h0000_0001, "slli_0");
        run_prog();

        // SLTI and x0 write discard.
        prog_q = '{addi(5'd1, 5'd0, 12'hFFD),
                   opi(3'b010, 5'd2, 5'd1, 12'hFFE), opi(3'b010, 5'd3, 5'd1, 12'hFFC),
                   addi(5'd0, 5'd0, 12'd5)};
        expect_item(0, 1, 32'hFFFF_FFFD, "slti_x1");
        expect_item(0, 2, 32'd1, "slti_lt");
        expect_item(0, 3, 32'd0, "slti_ge");
        expect_item(0, 0, 32'd0, "x0_write");
        run_prog();

        // SLTIU.
        prog_q = '{addi(5'd1, 5'd0, 12'd5),
                   opi(3'b011, 5'd2, 5'd1, 12'hFFF), opi(3'b011, 5'd3, 5'd1, 12'd5),
                   opi(3'b011, 5'd4, 5'd0, 12'd1)};
        expect_item(0, 2, 32'd1, "sltiu_max");
        expect_item(0, 3, 32'd0, "sltiu_eq");
        expect_item(0, 4, 32'd1, "sltiu_x0");
        run_prog();

        // Remaining R-type and shift-immediate forms, plus decode NOPs.
        prog_q = '{addi(5'd1, 5'd0, 12'hFF8), addi(5'd2, 5'd0, 12'd3),
                   enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3),
                   enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd4),
                   enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd5),
                   enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd6),
                   enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd7),
                   enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd8),
                   enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd9),
                   enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd10),
                   opi(3'b101, 5'd11, 5'd1, 12'h401),
                   opi(3'b101, 5'd12, 5'd1, 12'd28),
                   opi(3'b100, 5'd13, 5'd1, 12'h00F),
                   opi(3'b110, 5'd14, 5'd0, 12'h7FF),
                   enc_i(12'd0, 5'd0, 3'b000, 5'd15, 7'b0000011),
                   enc_i(12'd1, 5'd0, 3'b000, 5'd16, 7'b1111111)};
        expect_item(1, 0, 32'd64, "mix_pc");
        expect_item(0, 3, 32'hFFFF_FFF5, "sub");
        expect_item(0, 4, 32'hFFFF_FFFF, "sra");
        expect_item(0, 5, 32'h1FFF_FFFF, "srl");
        expect_item(0, 6, 32'hFFFF_FFC0, "sll");
        expect_item(0, 7, 32'd1, "slt");
        expect_item(0, 8, 32'd0, "sltu");
        expect_item(0, 9, 32'hFFFF_FFFB, "xor");
        expect_item(0, 10, 32'hFFFF_FFFB, "or");
        expect_item(0, 11, 32'hFFFF_FFFC, "srai");
        expect_item(0, 12, 32'h0000_000F, "srli");
        expect_item(0, 13, 32'hFFFF_FFF7, "xori");
        expect_item(0, 14, 32'h0000_07FF, "ori");
        expect_item(0, 15, 32'd0, "lw_bad_f3_nop");
        expect_item(0, 16, 32'd0, "bad_opcode_nop");
        run_prog();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
